// File: rtl/t01_lcd1602_rx.sv
// HD44780/LCD1602 bus responder: decodes writes into a DDRAM image and exposes the visible 16x2 window.
// Optional macro T01_LCD1602_RX_SYNC_EN adds 2-flop synchronizers on all bus pins.
module t01_lcd1602_rx #(
  parameter int COLS         = 16,
  parameter int CLEAR_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_en,
  input  logic              lcd_rs,
  input  logic              lcd_rw,
  input  logic [7:0]        lcd_data,
  output logic [COLS*8-1:0] row_1,
  output logic [COLS*8-1:0] row_2,
  output logic              display_on,
  output logic [6:0]        cursor_addr,
  output logic              busy,
  output logic              xfer_strobe,
  output logic              overrun
);

  localparam int CW    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int DEPTH = 40;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    line0_q [DEPTH];
  logic [7:0]    line1_q [DEPTH];
  logic [6:0]    ac_q;
  logic          inc_q;
  logic          display_on_q;
  logic          two_line_q;
  logic          cgram_q;
  logic          xfer_q;
  logic          overrun_q;
  logic          en_q;

  logic          en_s;
  logic          rs_s;
  logic          rw_s;
  logic [7:0]    data_s;
  logic          fall_d;
  logic          ac_valid_d;

`ifdef T01_LCD1602_RX_SYNC_EN
  logic [1:0] en_sync_q;
  logic [1:0] rs_sync_q;
  logic [1:0] rw_sync_q;
  logic [7:0] data_sync1_q;
  logic [7:0] data_sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sync_q    <= 2'b00;
      rs_sync_q    <= 2'b00;
      rw_sync_q    <= 2'b00;
      data_sync1_q <= 8'h00;
      data_sync2_q <= 8'h00;
    end else begin
      en_sync_q    <= {en_sync_q[0], lcd_en};
      rs_sync_q    <= {rs_sync_q[0], lcd_rs};
      rw_sync_q    <= {rw_sync_q[0], lcd_rw};
      data_sync1_q <= lcd_data;
      data_sync2_q <= data_sync1_q;
    end
  end

  assign en_s   = en_sync_q[1];
  assign rs_s   = rs_sync_q[1];
  assign rw_s   = rw_sync_q[1];
  assign data_s = data_sync2_q;
`else
  assign en_s   = lcd_en;
  assign rs_s   = lcd_rs;
  assign rw_s   = lcd_rw;
  assign data_s = lcd_data;
`endif

  assign fall_d     = en_q & ~en_s;
  assign ac_valid_d = (ac_q[5:0] < 6'd40);

  // Two-line mode jumps between the 0x00..0x27 and 0x40..0x67 banks; one-line mode is linear 0x00..0x4F.
  function automatic logic [6:0] step_ac(input logic [6:0] ac, input logic up, input logic two);
    logic [6:0] r;
    r = up ? ac + 7'd1 : ac - 7'd1;
    if (two) begin
      if (up && ac == 7'h27)       r = 7'h40;
      else if (up && ac == 7'h67)  r = 7'h00;
      else if (!up && ac == 7'h00) r = 7'h67;
      else if (!up && ac == 7'h40) r = 7'h27;
    end else begin
      if (up && ac == 7'h4F)       r = 7'h00;
      else if (!up && ac == 7'h00) r = 7'h4F;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ac_q         <= 7'h00;
      inc_q        <= 1'b1;
      display_on_q <= 1'b0;
      two_line_q   <= 1'b0;
      cgram_q      <= 1'b0;
      xfer_q       <= 1'b0;
      overrun_q    <= 1'b0;
      en_q         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        line0_q[i] <= 8'h20;
        line1_q[i] <= 8'h20;
      end
    end else begin
      en_q   <= en_s;
      xfer_q <= 1'b0;

      if (state_q == CLEAR) begin
        if (cnt_q == '0) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end

      if (fall_d && !rw_s) begin
        if (state_q == CLEAR) begin
          overrun_q <= 1'b1;
        end else begin
          xfer_q <= 1'b1;
          if (rs_s) begin
            if (!cgram_q) begin
              if (ac_valid_d) begin
                if (ac_q[6]) line1_q[ac_q[5:0]] <= data_s;
                else         line0_q[ac_q[5:0]] <= data_s;
              end
              ac_q <= step_ac(ac_q, inc_q, two_line_q);
            end
          end else begin
            // Instruction decode by highest set bit, HD44780 style.
            casez (data_s)
              8'b1???????: begin
                ac_q    <= data_s[6:0];
                cgram_q <= 1'b0;
              end
              8'b01??????: cgram_q    <= 1'b1;
              8'b001?????: two_line_q <= data_s[3];
              8'b0001????: begin
                if (!data_s[3]) ac_q <= step_ac(ac_q, data_s[2], two_line_q);
              end
              8'b00001???: display_on_q <= data_s[2];
              8'b000001??: inc_q        <= data_s[1];
              8'b0000001?: ac_q         <= 7'h00;
              8'b00000001: begin
                for (int i = 0; i < DEPTH; i++) begin
                  line0_q[i] <= 8'h20;
                  line1_q[i] <= 8'h20;
                end
                ac_q    <= 7'h00;
                inc_q   <= 1'b1;
                state_q <= CLEAR;
                cnt_q   <= CW'(CLEAR_CYCLES - 1);
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    row_1 = '0;
    row_2 = '0;
    for (int c = 0; c < COLS; c++) begin
      row_1[COLS*8-1-8*c -: 8] = line0_q[c];
      row_2[COLS*8-1-8*c -: 8] = line1_q[c];
    end
  end

  assign display_on  = display_on_q;
  assign cursor_addr = ac_q;
  assign busy        = (state_q == CLEAR);
  assign xfer_strobe = xfer_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_t01_lcd1602_rx.sv
// Directed bench for t01_lcd1602_rx: drives LCD bus writes and checks the mirrored display state.
module tb_t01_lcd1602_rx;

  localparam int COLS         = 16;
  localparam int CLEAR_CYCLES = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              lcd_en = 1'b0;
  logic              lcd_rs = 1'b0;
  logic              lcd_rw = 1'b0;
  logic [7:0]        lcd_data = 8'h00;
  logic [COLS*8-1:0] row_1;
  logic [COLS*8-1:0] row_2;
  logic              display_on;
  logic [6:0]        cursor_addr;
  logic              busy;
  logic              xfer_strobe;
  logic              overrun;

  int testsRun  = 0;
  int failCount = 0;
  int xferTotal = 0;
  int busyTotal = 0;
  int xferSnap;
  int busySnap;

  logic [127:0] allSpaces = {16{8'h20}};
  logic [127:0] textHello = "HELLO WORLD 1234";
  logic [127:0] textAlpha = "ABCDEFGHIJKLMNOP";
  logic [127:0] expRow;

  t01_lcd1602_rx #(.COLS(COLS), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .row_1(row_1), .row_2(row_2), .display_on(display_on),
    .cursor_addr(cursor_addr), .busy(busy), .xfer_strobe(xfer_strobe), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pulse and busy tallies are kept on posedge so the main sequence can snapshot them race-free at negedge.
  always @(posedge clk) begin
    if (xfer_strobe === 1'b1) xferTotal++;
    if (busy === 1'b1) busyTotal++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bus write: enable high for a cycle, falling edge, then settle time covering the optional synchronizer.
  task automatic applyStimulus(input logic rs, input logic rw, input logic [7:0] data);
    @(negedge clk);
    lcd_rs   = rs;
    lcd_rw   = rw;
    lcd_data = data;
    lcd_en   = 1'b1;
    @(negedge clk);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic sendText(input logic [127:0] text);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, text[127-8*i -: 8]);
  endtask

  task automatic waitNotBusy(input string tag);
    for (int i = 0; i < 200 && busy === 1'b1; i++) @(negedge clk);
    checkOutput(tag, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_row1", row_1, allSpaces);
    checkOutput("reset_row2", row_2, allSpaces);
    checkOutput("reset_cursor", 128'(cursor_addr), 128'(7'h00));
    checkOutput("reset_busy", 128'(busy), 128'(1'b0));
    checkOutput("reset_display", 128'(display_on), 128'(1'b0));
    checkOutput("reset_overrun", 128'(overrun), 128'(1'b0));
    checkOutput("reset_xfer", 128'(xfer_strobe), 128'(1'b0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    xferSnap = xferTotal;
    applyStimulus(1'b0, 1'b0, 8'h38);
    applyStimulus(1'b0, 1'b0, 8'h08);
    applyStimulus(1'b0, 1'b0, 8'h01);
    waitNotBusy("init_clear_done");
    applyStimulus(1'b0, 1'b0, 8'h06);
    applyStimulus(1'b0, 1'b0, 8'h0C);
    applyStimulus(1'b0, 1'b0, 8'h80);
    sendText(textHello);
    applyStimulus(1'b0, 1'b0, 8'hC0);
    sendText(textAlpha);
    checkOutput("init_row1", row_1, textHello);
    checkOutput("init_row2", row_2, textAlpha);
    checkOutput("init_display", 128'(display_on), 128'(1'b1));
    checkOutput("init_cursor", 128'(cursor_addr), 128'(7'h50));
    checkOutput("init_xfer_count", 128'(xferTotal - xferSnap), 128'(39));
    checkOutput("init_overrun", 128'(overrun), 128'(1'b0));

    applyStimulus(1'b0, 1'b0, 8'hA7);
    applyStimulus(1'b1, 1'b0, "X");
    checkOutput("wrap_cursor_mid", 128'(cursor_addr), 128'(7'h40));
    applyStimulus(1'b1, 1'b0, "Y");
    expRow = "YBCDEFGHIJKLMNOP";
    checkOutput("wrap_row2", row_2, expRow);
    checkOutput("wrap_cursor", 128'(cursor_addr), 128'(7'h41));

    applyStimulus(1'b0, 1'b0, 8'h04);
    applyStimulus(1'b0, 1'b0, 8'h80);
    applyStimulus(1'b1, 1'b0, "Q");
    expRow = "QELLO WORLD 1234";
    checkOutput("dec_row1", row_1, expRow);
    checkOutput("dec_cursor", 128'(cursor_addr), 128'(7'h67));
    applyStimulus(1'b0, 1'b0, 8'h14);
    checkOutput("shift_right_wrap", 128'(cursor_addr), 128'(7'h00));
    applyStimulus(1'b0, 1'b0, 8'h10);
    checkOutput("shift_left_wrap", 128'(cursor_addr), 128'(7'h67));
    applyStimulus(1'b0, 1'b0, 8'h18);
    checkOutput("shift_display_ignored", 128'(cursor_addr), 128'(7'h67));
    applyStimulus(1'b0, 1'b0, 8'h06);

    busySnap = busyTotal;
    applyStimulus(1'b0, 1'b0, 8'h01);
    applyStimulus(1'b1, 1'b0, "K");
    checkOutput("clear_overrun", 128'(overrun), 128'(1'b1));
    waitNotBusy("clear_done");
    @(negedge clk);
    checkOutput("clear_busy_cycles", 128'(busyTotal - busySnap), 128'(CLEAR_CYCLES));
    checkOutput("clear_row1", row_1, allSpaces);
    checkOutput("clear_row2", row_2, allSpaces);
    checkOutput("clear_cursor", 128'(cursor_addr), 128'(7'h00));

    xferSnap = xferTotal;
    applyStimulus(1'b1, 1'b1, 8'h41);
    checkOutput("read_xfer", 128'(xferTotal - xferSnap), 128'(0));
    checkOutput("read_row1", row_1, allSpaces);
    checkOutput("read_cursor", 128'(cursor_addr), 128'(7'h00));
    applyStimulus(1'b0, 1'b0, 8'h40);
    applyStimulus(1'b1, 1'b0, 8'h1F);
    checkOutput("cgram_xfer", 128'(xferTotal - xferSnap), 128'(2));
    checkOutput("cgram_row1", row_1, allSpaces);
    checkOutput("cgram_cursor", 128'(cursor_addr), 128'(7'h00));
    applyStimulus(1'b0, 1'b0, 8'h80);
    applyStimulus(1'b1, 1'b0, "Z");
    expRow = {8'h5A, {15{8'h20}}};
    checkOutput("ddram_row1", row_1, expRow);
    checkOutput("ddram_cursor", 128'(cursor_addr), 128'(7'h01));
    checkOutput("overrun_sticky", 128'(overrun), 128'(1'b1));

    applyStimulus(1'b0, 1'b0, 8'h01);
    checkOutput("midclear_busy", 128'(busy), 128'(1'b1));
    #2 rst = 1'b0;
    #1;
    checkOutput("async_busy", 128'(busy), 128'(1'b0));
    checkOutput("async_display", 128'(display_on), 128'(1'b0));
    checkOutput("async_overrun", 128'(overrun), 128'(1'b0));
    checkOutput("async_cursor", 128'(cursor_addr), 128'(7'h00));
    checkOutput("async_row1", row_1, allSpaces);
    #9 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_reset_busy", 128'(busy), 128'(1'b0));
    checkOutput("post_reset_xfer", 128'(xfer_strobe), 128'(1'b0));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/t01_lcd1602_rx.md
Name: t01_lcd1602_rx

Overview:
- Synthesizable HD44780/LCD1602-compatible responder on the parallel LCD bus: lcd_en, lcd_rs, lcd_rw, lcd_data[7:0].
- Decodes command and data writes into a DDRAM image, then presents the visible 16x2 window as two 128-bit rows.
- Sits opposite the team's LCD1602 driver. Used as a loopback checker in the integration bench and as an on-chip display mirror feeding the debug/logic-analyzer path.

Parameters:
- COLS, 16, visible characters per row. The row_1/row_2 width is COLS*8.
- CLEAR_CYCLES, 32, clk cycles the block stays busy after Clear Display, minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- lcd_en  input  1  bus enable strobe; transfer latched on its falling edge.
- lcd_rs  input  1  0 = command, 1 = data.
- lcd_rw  input  1  0 = write, 1 = read (reads not supported).
- lcd_data  input  8  bus byte.
- row_1  output  COLS*8  DDRAM 0x00..0x0F; char 0 at [COLS*8-1 -: 8].
- row_2  output  COLS*8  DDRAM 0x40..0x4F, same packing.
- display_on  output  1  D bit from Display Control.
- cursor_addr  output  7  current DDRAM address counter (AC).
- busy  output  1  high while Clear Display is executing.
- xfer_strobe  output  1  one-cycle pulse per accepted write.
- overrun  output  1  sticky; set when a strobe is dropped.

Behaviour:
- Reset (asynchronous, rst=0):
  - All 80 DDRAM cells = 0x20 (0x00..0x27 and 0x40..0x67).
  - AC = 0, increment mode = 1, display_on = 0, two_line = 0, cgram_mode = 0.
  - busy = 0, overrun = 0, xfer_strobe = 0, en_q = 0.
- Edge detect:
  - en_q registers lcd_en.
  - A falling edge is en_q=1 and lcd_en=0 at a posedge.
  - lcd_rs, lcd_rw and lcd_data are sampled at that same posedge.
  - All resulting register and output updates take effect at that edge, i.e. visible one cycle after the edge is sampled.
- Strobe filtering:
  - lcd_rw=1: strobe ignored. No state change, no xfer_strobe, no overrun.
  - busy=1: strobe dropped and overrun set. overrun is cleared only by reset.
- Commands (rs=0), decoded by highest set bit:
  - 0x01 Clear:
    - FSM IDLE -> CLEAR; busy=1 for CLEAR_CYCLES cycles.
    - All cells written to 0x20; AC=0; increment mode=1.
    - Return to IDLE on the last cycle, busy=0.
  - 0x02/0x03 Return home: AC=0; DDRAM unchanged.
  - 0x04..0x07 Entry mode: increment mode = bit1; S (bit0) ignored.
  - 0x08..0x0F Display control: display_on = bit2; cursor/blink bits ignored.
  - 0x10..0x1F Shift:
    - S/C=0 (bit3=0): AC moves right if bit2=1, else left, using the wrap rules below.
    - S/C=1: ignored.
  - 0x20..0x3F Function set: two_line = bit3; DL/F ignored.
  - 0x40..0x7F Set CGRAM address: cgram_mode=1.
  - 0x80..0xFF Set DDRAM address: AC = data[6:0]; cgram_mode=0.
- Data (rs=1):
  - cgram_mode=1: byte discarded; xfer_strobe still pulses.
  - Otherwise: write byte to DDRAM[AC] if AC is in 0x00..0x27 or 0x40..0x67 (invalid AC writes nothing), then step AC.
- AC step and wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - two_line=0: range is 0x00..0x4F linear, 0x4F -> 0x00 on increment, 0x00 -> 0x4F on decrement.
  - An invalid AC steps +/-1 modulo 128.
- xfer_strobe: pulses for every accepted rs/rw=0 write, including ignored-field commands and the edge that starts Clear.
- Rows:
  - row_1/row_2 are continuous views of DDRAM regardless of display_on.
  - Characters off the 16-wide window are stored but not shown.
- Reset mid-Clear: FSM -> IDLE immediately; full reset values apply.

Optional Feature:
- Macro: T01_LCD1602_RX_SYNC_EN.
- Defined:
  - lcd_en, lcd_rs, lcd_rw and lcd_data each pass through a 2-flop synchronizer, reset to 0, before edge detection.
  - Every update lags the pin-level falling edge by 2 additional cycles.
- Undefined:
  - Pins are used directly; bus assumed synchronous to clk.

Test Plan:
- Power-up sequence 0x38, 0x08, 0x01, 0x06, 0x0C, then 0x80 and data "HELLO WORLD 1234", then 0xC0 and "ABCDEFGHIJKLMNOP":
  - row_1 = "HELLO WORLD 1234", row_2 = "ABCDEFGHIJKLMNOP", display_on=1, two_line=1.
  - cursor_addr = 0x50.
  - 39 xfer_strobe pulses.
- Wrap, two_line=1: set 0xA7 (AC=0x27), write 'X' then 'Y':
  - DDRAM[0x27]='X'; 'Y' lands at 0x40 so row_2[127:120]=0x59; cursor_addr=0x41.
- Decrement mode: entry 0x04, set 0x80, write 'Q':
  - row_1 char0 = 'Q'; cursor_addr = 0x67.
- Clear timing:
  - Fill rows, send 0x01 -> busy high exactly CLEAR_CYCLES cycles; rows all 0x20; cursor_addr=0.
  - A strobe during busy -> overrun=1 and data not written.
- Read strobe / CGRAM:
  - rw=1 strobe with rs=1, data 0x41 -> no change and no strobe pulse.
  - 0x40 then data 0x1F -> DDRAM unchanged and xfer_strobe pulses.
  - 0x80 then 'Z' -> row_1 char0 = 'Z'.
- Async reset mid-Clear (rst low 1 cycle, not clock-aligned):
  - All outputs return to reset values immediately; busy=0 without waiting for a clock.
